// File: rtl/ram2_responder.sv
// ram2_responder: SRAM-side model of the Ram2 asynchronous bus with registered strobe decode,
// block-RAM storage, backdoor preload, and activity counters plus a sticky protocol-error flag.
module ram2_responder #(
   parameter int ADDR_W   = 18,
   parameter int DEPTH_W  = 10,
   parameter int READ_LAT = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  Ram2Addr,
   inout  wire  [15:0]        Ram2Data,
   input  logic               Ram2OE,
   input  logic               Ram2WE,
   input  logic               Ram2EN,
   input  logic               load_en,
   input  logic [DEPTH_W-1:0] load_addr,
   input  logic [15:0]        load_data,
   output logic               busy,
   output logic [15:0]        read_count,
   output logic [15:0]        write_count,
   output logic               proto_err
);
   typedef enum logic [1:0] {IDLE, READ_WAIT, READ_DRIVE, WRITE_ARMED} state_t;
   localparam logic [3:0] LAT = 4'(READ_LAT);
   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  s_addr_q, addr_q, addr_d;
   logic [15:0]        s_data_q, wdata_q, wdata_d, rdata_q;
   logic               s_oe_q, s_we_q, s_en_q;
   logic [3:0]         lat_q, lat_d;
   logic [15:0]        rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
   logic               err_q, err_d;
   logic               mem_we, rd_en, drive_on;
   logic [DEPTH_W-1:0] mem_wa;
   logic [15:0]        mem_wd;
   logic [15:0]        mem [2**DEPTH_W];
   logic               rd_req, wr_req, bad_req;
   assign rd_req  = ~s_en_q & ~s_oe_q & s_we_q;
   assign wr_req  = ~s_en_q & s_oe_q & ~s_we_q;
   assign bad_req = ~s_en_q & ~s_oe_q & ~s_we_q;
   // Raw pins gate the driver so contention ends the instant the controller lets go.
   assign drive_on    = (state_q == READ_DRIVE) & ~Ram2OE & ~Ram2EN & Ram2WE;
   assign Ram2Data    = drive_on ? rdata_q : 16'hzzzz;
   assign busy        = state_q != IDLE;
   assign read_count  = rd_cnt_q;
   assign write_count = wr_cnt_q;
   assign proto_err   = err_q;
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      lat_d    = lat_q;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      err_d    = err_q;
      mem_we   = 1'b0;
      mem_wa   = load_addr;
      mem_wd   = load_data;
      rd_en    = 1'b0;
      case (state_q)
         IDLE:
            if (rd_req) begin
               addr_d  = s_addr_q;
               lat_d   = LAT;
               state_d = READ_WAIT;
            end else if (wr_req) begin
               addr_d  = s_addr_q;
               wdata_d = s_data_q;
               state_d = WRITE_ARMED;
            end else if (bad_req) err_d = 1'b1;
            else if (load_en) mem_we = 1'b1;
         READ_WAIT:
            if (s_oe_q | s_en_q) state_d = IDLE;
            else if (lat_q == 4'd0) begin
               rd_en    = 1'b1;
               rd_cnt_d = rd_cnt_q + 16'd1;
               state_d  = READ_DRIVE;
            end else lat_d = lat_q - 4'd1;
         READ_DRIVE:
            if (s_oe_q | s_en_q) state_d = IDLE;
            else if (~s_we_q) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (s_addr_q != addr_q) begin
               addr_d  = s_addr_q;
               lat_d   = LAT;
               state_d = READ_WAIT;
            end
         WRITE_ARMED:
            if (s_we_q | s_en_q) begin
               mem_we   = 1'b1;
               mem_wa   = addr_q[DEPTH_W-1:0];
               mem_wd   = wdata_q;
               wr_cnt_d = wr_cnt_q + 16'd1;
               state_d  = IDLE;
            end else begin
               addr_d  = s_addr_q;
               wdata_d = s_data_q;
               err_d   = err_q | ~s_oe_q;
            end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         s_addr_q <= '0;
         s_data_q <= '0;
         s_oe_q   <= 1'b1;
         s_we_q   <= 1'b1;
         s_en_q   <= 1'b1;
         addr_q   <= '0;
         wdata_q  <= '0;
         lat_q    <= '0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         s_addr_q <= Ram2Addr;
         s_data_q <= Ram2Data;
         s_oe_q   <= Ram2OE;
         s_we_q   <= Ram2WE;
         s_en_q   <= Ram2EN;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         lat_q    <= lat_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
         err_q    <= err_d;
      end
   end
   // Storage survives reset; writes are held off while reset is asserted.
   always_ff @(posedge clk) begin
      if (mem_we && rst) mem[mem_wa] <= mem_wd;
      if (rd_en) rdata_q <= mem[addr_q[DEPTH_W-1:0]];
   end
endmodule

// File: tb/tb_ram2_responder.sv
// tb_ram2_responder: directed scenario tasks for ram2_responder with inline checks.
module tb_ram2_responder;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [17:0] Ram2Addr = '0;
   wire  [15:0] Ram2Data;
   logic        Ram2OE = 1'b1, Ram2WE = 1'b1, Ram2EN = 1'b1;
   logic        load_en = 1'b0;
   logic [9:0]  load_addr = '0;
   logic [15:0] load_data = '0;
   logic        busy, proto_err;
   logic [15:0] read_count, write_count;
   logic        tb_drv = 1'b0;
   logic [15:0] tb_data = '0;
   int          checks = 0, failures = 0;

   assign Ram2Data = tb_drv ? tb_data : 16'hzzzz;
   always #5 clk = ~clk;

   ram2_responder #(.ADDR_W(18), .DEPTH_W(10), .READ_LAT(1)) dut (
      .clk(clk), .rst(rst), .Ram2Addr(Ram2Addr), .Ram2Data(Ram2Data),
      .Ram2OE(Ram2OE), .Ram2WE(Ram2WE), .Ram2EN(Ram2EN),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .busy(busy), .read_count(read_count), .write_count(write_count), .proto_err(proto_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // The first posedge registers OE; data is driven READ_LAT+2 clocks after that.
   task automatic do_read(input logic [17:0] a, output logic [15:0] d);
      Ram2Addr = a; Ram2OE = 1'b0; Ram2EN = 1'b0;
      repeat (4) tick();
      d = Ram2Data;
      Ram2OE = 1'b1; Ram2EN = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) tick();
      checks += 4;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      if (read_count !== 16'h0) begin failures++; $display("FAIL reset_rc got=%h exp=0000", read_count); end
      if (write_count !== 16'h0) begin failures++; $display("FAIL reset_wc got=%h exp=0000", write_count); end
      if (proto_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", proto_err); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_preload();
      load_en = 1'b1; load_addr = 10'h005; load_data = 16'hBEEF;
      tick();
      load_en = 1'b0;
      Ram2Addr = 18'h00005; Ram2OE = 1'b0; Ram2EN = 1'b0;
      tick();
      tick();
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL preload_busy got=%b exp=1", busy); end
      tick();
      checks++;
      if (Ram2Data === 16'hBEEF) begin failures++; $display("FAIL preload_early got=%h exp=undriven", Ram2Data); end
      tick();
      checks += 2;
      if (Ram2Data !== 16'hBEEF) begin failures++; $display("FAIL preload_data got=%h exp=beef", Ram2Data); end
      if (read_count !== 16'd1) begin failures++; $display("FAIL preload_rc got=%h exp=0001", read_count); end
      Ram2OE = 1'b1; Ram2EN = 1'b1;
      #1;
      checks++;
      if (Ram2Data === 16'hBEEF) begin failures++; $display("FAIL preload_release got=%h exp=undriven", Ram2Data); end
      repeat (2) tick();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL preload_idle got=%b exp=0", busy); end
   endtask

   task automatic test_write_read();
      logic [15:0] d;
      Ram2Addr = 18'h00012; tb_data = 16'h1234; tb_drv = 1'b1; Ram2WE = 1'b0; Ram2EN = 1'b0;
      repeat (3) tick();
      Ram2WE = 1'b1; Ram2EN = 1'b1; tb_drv = 1'b0;
      tick();
      checks++;
      if (write_count !== 16'd0) begin failures++; $display("FAIL wr_early got=%h exp=0000", write_count); end
      tick();
      checks++;
      if (write_count !== 16'd1) begin failures++; $display("FAIL wr_count got=%h exp=0001", write_count); end
      do_read(18'h00012, d);
      checks++;
      if (d !== 16'h1234) begin failures++; $display("FAIL wr_readback got=%h exp=1234", d); end
      do_read(18'h00412, d);
      checks += 2;
      if (d !== 16'h1234) begin failures++; $display("FAIL wr_alias got=%h exp=1234", d); end
      if (read_count !== 16'd3) begin failures++; $display("FAIL wr_rc got=%h exp=0003", read_count); end
   endtask

   task automatic test_aborted_read();
      Ram2Addr = 18'h00012; Ram2OE = 1'b0; Ram2EN = 1'b0;
      tick();
      Ram2OE = 1'b1; Ram2EN = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (Ram2Data === 16'h1234) begin failures++; $display("FAIL abort_drive cyc=%0d got=%h exp=undriven", i, Ram2Data); end
      end
      checks += 2;
      if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
      if (read_count !== 16'd3) begin failures++; $display("FAIL abort_rc got=%h exp=0003", read_count); end
   endtask

   task automatic test_illegal();
      logic [15:0] d;
      Ram2OE = 1'b0; Ram2WE = 1'b0; Ram2EN = 1'b0;
      repeat (2) tick();
      Ram2OE = 1'b1; Ram2WE = 1'b1; Ram2EN = 1'b1;
      tick();
      checks++;
      if (proto_err !== 1'b1) begin failures++; $display("FAIL illegal_set got=%b exp=1", proto_err); end
      do_read(18'h00012, d);
      checks += 2;
      if (d !== 16'h1234) begin failures++; $display("FAIL illegal_read got=%h exp=1234", d); end
      if (proto_err !== 1'b1) begin failures++; $display("FAIL illegal_sticky got=%b exp=1", proto_err); end
   endtask

   task automatic test_wrap();
      logic [15:0] d;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      checks++;
      if (proto_err !== 1'b0) begin failures++; $display("FAIL wrap_errclr got=%b exp=0", proto_err); end
      Ram2Addr = 18'h00100;
      for (int i = 0; i < 65535; i++) begin
         tb_data = 16'(i); tb_drv = 1'b1; Ram2WE = 1'b0; Ram2EN = 1'b0;
         tick();
         Ram2WE = 1'b1; Ram2EN = 1'b1; tb_drv = 1'b0;
         tick();
      end
      tick();
      checks++;
      if (write_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_ffff got=%h exp=ffff", write_count); end
      tb_data = 16'h5555; tb_drv = 1'b1; Ram2WE = 1'b0; Ram2EN = 1'b0;
      tick();
      Ram2WE = 1'b1; Ram2EN = 1'b1; tb_drv = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL wrap_armed got=%b exp=1", busy); end
      load_en = 1'b1; load_addr = 10'h005; load_data = 16'hDEAD;
      tick();
      load_en = 1'b0;
      checks++;
      if (write_count !== 16'h0000) begin failures++; $display("FAIL wrap_zero got=%h exp=0000", write_count); end
      do_read(18'h00005, d);
      checks++;
      if (d !== 16'hBEEF) begin failures++; $display("FAIL wrap_load_ignored got=%h exp=beef", d); end
      do_read(18'h00100, d);
      checks++;
      if (d !== 16'h5555) begin failures++; $display("FAIL wrap_lastwrite got=%h exp=5555", d); end
   endtask

   task automatic test_reset_mid_read();
      logic [15:0] d;
      Ram2Addr = 18'h00012; Ram2OE = 1'b0; Ram2EN = 1'b0;
      repeat (4) tick();
      checks++;
      if (Ram2Data !== 16'h1234) begin failures++; $display("FAIL rmid_drive got=%h exp=1234", Ram2Data); end
      rst = 1'b0;
      #1;
      checks += 4;
      if (Ram2Data === 16'h1234) begin failures++; $display("FAIL rmid_release got=%h exp=undriven", Ram2Data); end
      if (read_count !== 16'd0) begin failures++; $display("FAIL rmid_rc got=%h exp=0000", read_count); end
      if (write_count !== 16'd0) begin failures++; $display("FAIL rmid_wc got=%h exp=0000", write_count); end
      if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
      Ram2OE = 1'b1; Ram2EN = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      do_read(18'h00012, d);
      checks += 2;
      if (d !== 16'h1234) begin failures++; $display("FAIL rmid_mem got=%h exp=1234", d); end
      if (read_count !== 16'd1) begin failures++; $display("FAIL rmid_rc_after got=%h exp=0001", read_count); end
   endtask

   initial begin
      test_reset();
      test_preload();
      test_write_read();
      test_aborted_read();
      test_illegal();
      test_wrap();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
